// File: rtl/calc_pkg.sv
// Shared calculator datapath types: divider FSM states and sign-magnitude packing.
package calc_pkg;

  localparam int DATA_W   = 8;
  localparam int SIGN_BIT = DATA_W;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } divStateT;

  // Sign-magnitude pack; a zero magnitude always carries a positive sign.
  function automatic logic [DATA_W:0] sm_pack(input logic sign, input logic [DATA_W-1:0] mag);
    return {sign & (|mag), mag};
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift in the next dividend bit, trial-subtract, emit quotient bit.
module div_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] remIn,
  input  logic [WIDTH-1:0] quoIn,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] remOut,
  output logic [WIDTH-1:0] quoOut
);

  logic [WIDTH:0] shifted;
  logic           fits;

  // The incoming remainder is always below the divisor, so only the shifted value needs WIDTH+1 bits.
  always_comb begin
    shifted = {remIn, quoIn[WIDTH-1]};
    fits    = shifted >= {1'b0, divisor};
    remOut  = fits ? (shifted[WIDTH-1:0] - divisor) : shifted[WIDTH-1:0];
    quoOut  = {quoIn[WIDTH-2:0], fits};
  end

endmodule

// File: rtl/div_seq.sv
// Sequential sign-magnitude restoring divider, one quotient bit per clock.
// Optional DIV_BY_ZERO_ERR_EN: flag zero divisor via err and finish early.
module div_seq
  import calc_pkg::*;
#(
  parameter int WIDTH = DATA_W
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [WIDTH:0] numberA,
  input  logic [WIDTH:0] numberB,
  output logic           busy,
  output logic           done,
  output logic [WIDTH:0] quotient,
  output logic [WIDTH:0] remainder,
  output logic           err
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  divStateT         state, nextState;
  logic [WIDTH-1:0] remReg, quoReg, divReg;
  logic [WIDTH-1:0] stepRem, stepQuo;
  logic [CNT_W-1:0] iterCnt;
  logic             signQ, signR;
  logic             lastIter;

  div_step #(.WIDTH(WIDTH)) uStep (
    .remIn  (remReg),
    .quoIn  (quoReg),
    .divisor(divReg),
    .remOut (stepRem),
    .quoOut (stepQuo)
  );

`ifdef DIV_BY_ZERO_ERR_EN
  logic divZero;

  assign lastIter = divZero || (iterCnt == LAST_ITER);
  assign err      = done & divZero;
`else
  assign lastIter = iterCnt == LAST_ITER;
  assign err      = 1'b0;
`endif

  always_comb begin
    nextState = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: if (start) nextState = RUN;
      RUN: begin
        busy = 1'b1;
        if (lastIter) nextState = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      remReg    <= '0;
      quoReg    <= '0;
      divReg    <= '0;
      iterCnt   <= '0;
      signQ     <= 1'b0;
      signR     <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
`ifdef DIV_BY_ZERO_ERR_EN
      divZero   <= 1'b0;
`endif
    end else begin
      state <= nextState;
      case (state)
        IDLE: if (start) begin
          // Dividend magnitude seeds the quotient register and is shifted out MSB first.
          quoReg  <= numberA[WIDTH-1:0];
          divReg  <= numberB[WIDTH-1:0];
          remReg  <= '0;
          iterCnt <= '0;
          signQ   <= numberA[WIDTH] ^ numberB[WIDTH];
          signR   <= numberA[WIDTH];
`ifdef DIV_BY_ZERO_ERR_EN
          divZero <= numberB[WIDTH-1:0] == '0;
`endif
        end
        RUN: begin
          remReg  <= stepRem;
          quoReg  <= stepQuo;
          iterCnt <= iterCnt + 1'b1;
          if (lastIter) begin
            quotient  <= sm_pack(signQ, stepQuo);
            remainder <= sm_pack(signR, stepRem);
`ifdef DIV_BY_ZERO_ERR_EN
            // quoReg still holds the untouched dividend magnitude on the early exit.
            if (divZero) begin
              quotient  <= sm_pack(signQ, '1);
              remainder <= sm_pack(signR, quoReg);
            end
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule
